// File: rtl/param_register_file.sv
// Two-write, two-read register file with per-register pending (busy) bits.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module param_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              busy0,
  output logic              busy1,
  output logic              wr_conflict
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              conf_q;
  logic              conf_d;

  logic wr0_ok;
  logic wr1_ok;

  assign wr0_ok = we0 && (waddr0 != '0);
  assign wr1_ok = we1 && (waddr1 != '0);

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr0_ok) regs_d[waddr0] = wdata0;
    if (wr1_ok) regs_d[waddr1] = wdata1;
  end

  // Clears first, then set, so a same-cycle set survives.
  always_comb begin
    busy_d = busy_q;
    if (we0)      busy_d[waddr0]    = 1'b0;
    if (we1)      busy_d[waddr1]    = 1'b0;
    if (busy_set) busy_d[busy_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    conf_d = we0 && we1 && (waddr0 == waddr1) && (waddr0 != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      conf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_fn(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = regs_q[a];
`ifdef REGFILE_BYPASS_EN
    if (reset_n) begin
      if (wr0_ok && (waddr0 == a)) v = wdata0;
      if (wr1_ok && (waddr1 == a)) v = wdata1;
    end
`endif
    if (a == '0) v = '0;
    return v;
  endfunction

  assign rdata0 = rd_fn(raddr0);
  assign rdata1 = rd_fn(raddr1);

  assign busy0 = busy_q[raddr0] && (raddr0 != '0);
  assign busy1 = busy_q[raddr1] && (raddr1 != '0);

  assign wr_conflict = conf_q;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: directed scenarios then random traffic
// checked against an array-based reference model.
module tb_param_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk;
  logic          run;
  logic          reset_n;
  logic          we0, we1, busy_set;
  logic [AW-1:0] waddr0, waddr1, raddr0, raddr1, busy_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
  logic          busy0, busy1, wr_conflict;

  int compared;
  int mismatched;

  logic [DW-1:0] m_mem [NR];
  bit            m_busy [NR];
  bit            m_conf;

  param_register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .busy0(busy0), .busy1(busy1),
    .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (reset_n === 1'b1) begin
      if (we0 && waddr0 == a) v = wdata0;
      if (we1 && waddr1 == a) v = wdata1;
    end
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rdata0"}, 64'(rdata0), 64'(exp_rd(raddr0)));
    chk({tag, ".rdata1"}, 64'(rdata1), 64'(exp_rd(raddr1)));
    chk({tag, ".busy0"}, 64'(busy0), 64'(m_busy[raddr0]));
    chk({tag, ".busy1"}, 64'(busy1), 64'(m_busy[raddr1]));
    chk({tag, ".conf"}, 64'(wr_conflict), 64'(m_conf));
  endtask

  task automatic drive(input bit e0, input int a0, input logic [DW-1:0] d0,
                       input bit e1, input int a1, input logic [DW-1:0] d1,
                       input bit bs, input int ba);
    we0 = e0; waddr0 = AW'(a0); wdata0 = d0;
    we1 = e1; waddr1 = AW'(a1); wdata1 = d1;
    busy_set = bs; busy_addr = AW'(ba);
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  // Rising edge: apply the written rules to the model, then settle.
  task automatic tick();
    @(posedge clk);
    m_conf = we0 && we1 && waddr0 == waddr1 && waddr0 != 0;
    if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
    if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
    if (we0) m_busy[waddr0] = 1'b0;
    if (we1) m_busy[waddr1] = 1'b0;
    if (busy_set) m_busy[busy_addr] = 1'b1;
    m_busy[0] = 1'b0;
    #1;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    run = 1'b0;
    reset_n = 1'b1;
    raddr0 = '0;
    raddr1 = '0;
    idle();

    // Reset with clock stopped
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
    for (int a = 0; a < NR; a++) begin
      raddr0 = AW'(a);
      raddr1 = AW'(NR - 1 - a);
      #1;
      chk("rst.rdata0", 64'(rdata0), 64'd0);
      chk("rst.rdata1", 64'(rdata1), 64'd0);
    end
    chk("rst.busy0", 64'(busy0), 64'd0);
    chk("rst.busy1", 64'(busy1), 64'd0);
    chk("rst.conf", 64'(wr_conflict), 64'd0);
    run = 1'b1;
    tick();

    // Same-address dual write
    raddr0 = 5; raddr1 = 5;
    drive(1, 5, 32'h1111_1111, 1, 5, 32'h2222_2222, 0, 0);
    #1 check_all("dual.pre");
    tick();
    chk("dual.reg5", 64'(rdata0), 64'h2222_2222);
    chk("dual.conf", 64'(wr_conflict), 64'd1);
    idle();
    tick();
    chk("dual.conf_off", 64'(wr_conflict), 64'd0);

    // Register zero
    raddr0 = 0; raddr1 = 0;
    drive(1, 0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1, 0);
    #1 chk("r0.pre", 64'(rdata0), 64'd0);
    tick();
    chk("r0.rdata", 64'(rdata0), 64'd0);
    chk("r0.busy", 64'(busy0), 64'd0);
    chk("r0.conf", 64'(wr_conflict), 64'd0);

    // Busy tracking at 7
    raddr0 = 7; raddr1 = 7;
    drive(0, 0, '0, 0, 0, '0, 1, 7);
    tick();
    chk("busy.set", 64'(busy0), 64'd1);
    idle();
    tick();
    chk("busy.hold", 64'(busy0), 64'd1);
    drive(1, 7, 32'h77, 0, 0, '0, 1, 7);
    tick();
    chk("busy.setwins", 64'(busy1), 64'd1);
    drive(0, 0, '0, 1, 7, 32'h78, 0, 0);
    tick();
    chk("busy.clear", 64'(busy0), 64'd0);
    chk("busy.data", 64'(rdata0), 64'h78);
    idle();

    // Bypass / same-cycle visibility at 3
    raddr0 = 3; raddr1 = 7;
    drive(1, 3, 32'hCAFE_F00D, 0, 0, '0, 0, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp.same", 64'(rdata0), 64'hCAFE_F00D);
`else
    chk("byp.old", 64'(rdata0), 64'd0);
`endif
    tick();
    chk("byp.next", 64'(rdata0), 64'hCAFE_F00D);
    idle();

    // Mid-operation reset
    raddr0 = 9; raddr1 = 9;
    drive(1, 9, 32'h5, 0, 0, '0, 1, 9);
    tick();
    chk("mid.pre_reg", 64'(rdata0), 64'h5);
    chk("mid.pre_busy", 64'(busy0), 64'd1);
    drive(1, 9, 32'h9, 1, 9, 32'h9, 1, 9);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid.rd0", 64'(rdata0), 64'd0);
    chk("mid.rd1", 64'(rdata1), 64'd0);
    chk("mid.busy0", 64'(busy0), 64'd0);
    chk("mid.busy1", 64'(busy1), 64'd0);
    chk("mid.conf", 64'(wr_conflict), 64'd0);
    @(posedge clk);
    #1;
    chk("mid.hold_rd", 64'(rdata0), 64'd0);
    chk("mid.hold_busy", 64'(busy0), 64'd0);
    idle();
    #2 reset_n = 1'b1;
    tick();
    chk("mid.reg9", 64'(rdata0), 64'd0);
    chk("mid.busy9", 64'(busy0), 64'd0);

    // Random traffic, collisions encouraged via narrow address range
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? 3 : NR - 1;
      drive($urandom_range(0, 1), $urandom_range(0, lim), $urandom,
            $urandom_range(0, 1), $urandom_range(0, lim), $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, lim));
      raddr0 = AW'($urandom_range(0, lim));
      raddr1 = AW'($urandom_range(0, NR - 1));
      #1 check_all("rnd.pre");
      tick();
      check_all("rnd.post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, giving the address width; the register count is 2**ADDR_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports we0 (input, 1), waddr0 (input, ADDR_W) and wdata0 (input, DATA_W): write port 0.
REQ-006 The block SHALL have ports we1 (input, 1), waddr1 (input, ADDR_W) and wdata1 (input, DATA_W): write port 1.
REQ-007 The block SHALL have ports raddr0 and raddr1 (input, ADDR_W each): read addresses.
REQ-008 The block SHALL have ports rdata0 and rdata1 (output, DATA_W each): read data.
REQ-009 The block SHALL have ports busy_set (input, 1) and busy_addr (input, ADDR_W): mark a destination register as pending.
REQ-010 The block SHALL have ports busy0 and busy1 (output, 1 each): pending status of raddr0 and raddr1.
REQ-011 The block SHALL have port wr_conflict (output, 1): registered pulse flagging a same-address dual write.

Function
REQ-012 Register 0 SHALL always read as zero; writes to it SHALL be ignored; its busy bit SHALL always read 0.
REQ-013 On each rising clk edge, wdata0 SHALL be stored at waddr0 when we0=1, and wdata1 at waddr1 when we1=1.
REQ-014 When we0 and we1 are both 1 and waddr0 equals waddr1, port 1 SHALL win and wdata0 SHALL be discarded.
REQ-015 Reads SHALL be combinational from stored state: rdataN = reg[raddrN], subject to REQ-024.
REQ-016 Each register SHALL have one busy bit: busy_set=1 sets bit busy_addr at the clock edge; a write through either port clears the written address's bit.
REQ-017 When a busy set and a write clear target the same address in the same cycle, set SHALL win and the bit SHALL end at 1.
REQ-018 busy0 and busy1 SHALL reflect registered busy state of raddr0 and raddr1 with no bypass; each SHALL be 0 for address 0.
REQ-019 wr_conflict SHALL be 1 for exactly the cycle after an edge at which we0=we1=1 and waddr0=waddr1 is nonzero; otherwise 0.
REQ-020 Writes to register 0 SHALL never assert wr_conflict.

Reset
REQ-021 When reset_n=0, all registers and busy bits SHALL clear to 0 immediately, with no clock required.
REQ-022 While reset_n=0, rdata0, rdata1, busy0, busy1 and wr_conflict SHALL be 0, and writes and busy_set SHALL be ignored.
REQ-023 Reset asserted mid-operation SHALL discard any write or busy_set sampled in that cycle; the first update SHALL occur at the first rising edge after reset_n returns to 1.

Configuration
REQ-024 When macro REGFILE_BYPASS_EN is defined, a read SHALL return the write data being written to a nonzero address in the same cycle, with port 1 taking priority over port 0.
REQ-025 When REGFILE_BYPASS_EN is not defined, reads SHALL return only previously stored data; same-cycle write data SHALL be visible from the next cycle.
REQ-026 REGFILE_BYPASS_EN SHALL NOT affect busy0, busy1 or wr_conflict.

Verification
REQ-027 Test reset: pulse reset_n low with no clock, then read all addresses; every read SHALL return 0, busy0=busy1=0 and wr_conflict=0.
REQ-028 Test dual write: drive we0=we1=1 with waddr0=waddr1=5, wdata0=0x11111111 and wdata1=0x22222222; reg5 SHALL read 0x22222222 and wr_conflict SHALL be 1 for one cycle.
REQ-029 Test register 0: write 0xDEADBEEF to address 0 through both ports and set busy_addr=0; reading address 0 SHALL give rdata=0, busy=0 and wr_conflict=0.
REQ-030 Test busy tracking: issue busy_set at address 7, then a later write to address 7 with busy_set at address 7 in the same cycle; busy SHALL read 1, 1 and 1 across these cycles, and a following write alone SHALL clear busy to 0.
REQ-031 Test bypass: write 0xCAFEF00D to address 3 while raddr0=3; with REGFILE_BYPASS_EN defined, rdata0 SHALL equal 0xCAFEF00D in the same cycle; without it, rdata0 SHALL show the old value and then 0xCAFEF00D the next cycle.
REQ-032 Test mid-operation reset: with reg9=0x5 and busy9=1, assert reset_n=0 in the same cycle as a write of 0x9 to address 9; after release, reg9 SHALL read 0 and busy9 SHALL read 0.
